// File: rtl/sram_bus_responder.sv
// CPU ibus/dbus responder for a 32-bit async SRAM (two 16-bit chips, shared CE), fixed wait cycles.
// Define SRAM_READ_CACHE_EN to add a single-entry last-read buffer that answers repeated reads without an SRAM cycle.
module sram_bus_responder #(
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        bus_addr,
    input  logic [3:0]         bus_byte_en,
    input  logic               bus_read,
    input  logic               bus_write,
    input  logic [31:0]        bus_write_data,
    output logic [31:0]        bus_read_data,
    output logic               bus_stall,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_data_out,
    output logic               sram_data_oe,
    input  logic [31:0]        sram_data_in,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic [3:0]         sram_be_n
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES);

    if (WAIT_CYCLES < 2 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
        $error("sram_bus_responder: WAIT_CYCLES must be in 2..15");
    end

    logic [1:0]         state, state_nxt;
    logic [3:0]         cnt, cnt_nxt;
    logic               is_write, write_nxt, aborted;
    logic [3:0]         be_lat, be_nxt;
    logic               req, ack, accept, cache_hit, read_capture;
    logic               in_access_nxt, we_window_nxt;
    logic [SRAM_AW-1:0] word_addr;
    logic               unused_addr_bits;

    // Handshake: the CPU holds bus_read/bus_write (and may change addr/data freely) until it
    // sees bus_stall low; the transfer completes in the cycle where the request is high and
    // bus_stall is low (the DONE cycle), and the CPU advances at the following edge.
    assign req          = bus_read | bus_write;
    assign ack          = (state == S_DONE);
    assign bus_stall    = req & ~ack;
    assign word_addr    = bus_addr[SRAM_AW+1:2];
    assign accept       = (state == S_IDLE) && req && !cache_hit;
    assign read_capture = (state == S_ACCESS) && (cnt == 4'd1) && !is_write;
    assign write_nxt    = accept ? bus_write : is_write;
    assign be_nxt       = accept ? bus_byte_en : be_lat;
    assign in_access_nxt = (state_nxt == S_ACCESS);
    // One setup cycle (cnt==WAIT_CYCLES) and one hold cycle (cnt==1) around the write pulse.
    assign we_window_nxt = (WAIT_CYCLES == 2) ? (cnt_nxt == 4'd2)
                                              : ((cnt_nxt > 4'd1) && (cnt_nxt < CNT_LOAD));
    assign unused_addr_bits = ^{bus_addr[31:SRAM_AW+2], bus_addr[1:0]};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (cache_hit) begin
                    state_nxt = S_DONE;
                end else if (req) begin
                    state_nxt = S_ACCESS;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            S_ACCESS: begin
                cnt_nxt = cnt - 4'd1;
                // A flushed request still finishes its SRAM cycle but is never acknowledged.
                if (cnt == 4'd1) state_nxt = (aborted || !req) ? S_IDLE : S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef SRAM_READ_CACHE_EN
    logic               cache_valid;
    logic [SRAM_AW-1:0] cache_addr;
    logic [31:0]        cache_data;

    assign cache_hit = (state == S_IDLE) && bus_read && !bus_write && cache_valid
                       && (cache_addr == word_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            cache_valid <= 1'b0;
            cache_addr  <= '0;
            cache_data  <= '0;
        end else if (accept && bus_write) begin
            cache_valid <= 1'b0;
        end else if (read_capture) begin
            cache_valid <= 1'b1;
            cache_addr  <= sram_addr;
            cache_data  <= sram_data_in;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            is_write      <= 1'b0;
            aborted       <= 1'b0;
            be_lat        <= '0;
            bus_read_data <= '0;
            sram_addr     <= '0;
            sram_data_out <= '0;
            sram_data_oe  <= 1'b0;
            sram_ce_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            sram_we_n     <= 1'b1;
            sram_be_n     <= 4'hF;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                is_write  <= bus_write;
                be_lat    <= bus_byte_en;
                sram_addr <= word_addr;
                aborted   <= 1'b0;
                if (bus_write) sram_data_out <= bus_write_data;
            end else if (state == S_ACCESS && !req) begin
                aborted <= 1'b1;
            end
            // Strobes are registered from next-state so the pads never see decode glitches.
            sram_ce_n    <= ~in_access_nxt;
            sram_oe_n    <= ~(in_access_nxt && !write_nxt);
            sram_data_oe <= in_access_nxt && write_nxt;
            sram_we_n    <= ~(in_access_nxt && write_nxt && we_window_nxt);
            sram_be_n    <= in_access_nxt ? ~be_nxt : 4'hF;
            if (read_capture) begin
                bus_read_data <= sram_data_in;
            end
`ifdef SRAM_READ_CACHE_EN
            else if (cache_hit) begin
                bus_read_data <= cache_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_sram_bus_responder.sv
// Self-checking bench for sram_bus_responder: SRAM pad model, reference memory and read-data scoreboard.
// Follows SRAM_READ_CACHE_EN so the expected stall lengths match the configured build.
`timescale 1ns/1ps
module tb_sram_bus_responder;

    localparam int W  = 4;
    localparam int AW = 18;
`ifdef SRAM_READ_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [31:0]   bus_addr;
    logic [3:0]    bus_byte_en;
    logic          bus_read;
    logic          bus_write;
    logic [31:0]   bus_write_data;
    logic [31:0]   bus_read_data;
    logic          bus_stall;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_data_out;
    logic          sram_data_oe;
    logic [31:0]   sram_data_in;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic [3:0]    sram_be_n;

    sram_bus_responder #(.SRAM_AW(AW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .bus_addr(bus_addr), .bus_byte_en(bus_byte_en),
        .bus_read(bus_read), .bus_write(bus_write),
        .bus_write_data(bus_write_data), .bus_read_data(bus_read_data),
        .bus_stall(bus_stall),
        .sram_addr(sram_addr), .sram_data_out(sram_data_out),
        .sram_data_oe(sram_data_oe), .sram_data_in(sram_data_in),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
    );

    // ---------------- clock / reset ----------------
    int cyc;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- async SRAM pad model ----------------
    logic [31:0] sram_mem [0:(1<<AW)-1];
    assign sram_data_in = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 32'hFFFF_FFFF;

    always @(posedge sram_we_n) begin
        if (!rst && !sram_ce_n && sram_data_oe) begin
            for (int b = 0; b < 4; b++)
                if (!sram_be_n[b]) sram_mem[sram_addr][8*b +: 8] = sram_data_out[8*b +: 8];
        end
    end

    // ---------------- scoreboard / reference state ----------------
    int          vectors;
    int          miscompares;
    logic [31:0] exp_q[$];
    logic [31:0] ref_mem [int];
    bit          bc_valid;
    logic [AW-1:0] bc_addr;

    int          m_stall, m_exp_stall, m_ce, m_we, m_oe, m_doe;
    int          m_ce_first, m_ce_last, m_we_first, m_we_last;
    logic [3:0]  m_be;
    logic [AW-1:0] m_addr;
    logic [31:0] m_rdata;

    // ---------------- driver ----------------
    // Starts a request in the current (IDLE) cycle, monitors strobes once per cycle on the
    // falling edge, and releases the request right after the DONE->IDLE edge.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wdata);
        logic        hit;
        logic [31:0] word;
        logic [31:0] exp;
        int          k;
        bit          done;
        k    = int'(addr[AW+1:2]);
        word = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
        hit  = CACHE_EN && rd && !wr && bc_valid && (bc_addr == addr[AW+1:2]);
        m_exp_stall = hit ? 1 : W + 1;
        if (wr) begin
            for (int b = 0; b < 4; b++) if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
            ref_mem[k] = word;
            bc_valid   = 1'b0;
        end else begin
            exp_q.push_back(word);
            if (!hit) begin
                bc_valid = 1'b1;
                bc_addr  = addr[AW+1:2];
            end
        end
        bus_read = rd; bus_write = wr; bus_addr = addr;
        bus_byte_en = be; bus_write_data = wdata;
        m_stall = 0; m_ce = 0; m_we = 0; m_oe = 0; m_doe = 0;
        m_ce_first = -1; m_ce_last = -1; m_we_first = -1; m_we_last = -1;
        m_be = 4'hF; m_addr = '0; m_rdata = '0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!sram_ce_n) begin
                if (m_ce_first < 0) begin
                    m_ce_first = i; m_be = sram_be_n; m_addr = sram_addr;
                end
                m_ce_last = i; m_ce++;
            end
            if (!sram_we_n) begin
                if (m_we_first < 0) m_we_first = i;
                m_we_last = i; m_we++;
            end
            if (!sram_oe_n) m_oe++;
            if (sram_data_oe) m_doe++;
            if (!bus_stall) begin
                done = 1'b1;
                m_rdata = bus_read_data;
            end else begin
                m_stall++;
                if (i == 1) begin
                    bus_addr       = $urandom();
                    bus_write_data = $urandom();
                    bus_byte_en    = 4'($urandom_range(0, 15));
                end
            end
        end
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL timeout: addr %h stall still high after 40 cycles, want low", addr);
            if (rd && !wr) void'(exp_q.pop_front());
        end else if (rd && !wr) begin
            exp = exp_q.pop_front();
            vectors++;
            if (m_rdata !== exp) begin
                miscompares++;
                $display("FAIL scoreboard_read: addr %h got %h want %h", addr, m_rdata, exp);
            end
        end
        @(posedge clk); #1;
        bus_read = 1'b0; bus_write = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (sram_ce_n !== 1'b1) begin miscompares++; $display("FAIL reset_ce_n: got %b want 1", sram_ce_n); end
        vectors++; if (sram_oe_n !== 1'b1) begin miscompares++; $display("FAIL reset_oe_n: got %b want 1", sram_oe_n); end
        vectors++; if (sram_we_n !== 1'b1) begin miscompares++; $display("FAIL reset_we_n: got %b want 1", sram_we_n); end
        vectors++; if (sram_be_n !== 4'hF) begin miscompares++; $display("FAIL reset_be_n: got %h want f", sram_be_n); end
        vectors++; if (bus_stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", bus_stall); end
        vectors++; if (bus_read_data !== 32'h0) begin miscompares++; $display("FAIL reset_read_data: got %h want 0", bus_read_data); end
        vectors++; if (sram_data_oe !== 1'b0) begin miscompares++; $display("FAIL reset_data_oe: got %b want 0", sram_data_oe); end
        vectors++; if (sram_addr !== '0) begin miscompares++; $display("FAIL reset_sram_addr: got %h want 0", sram_addr); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        do_access(1'b0, 1'b1, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF);
        vectors++; if (m_stall !== W + 1) begin miscompares++; $display("FAIL wr_stall: got %0d want %0d", m_stall, W + 1); end
        vectors++; if (m_addr !== 18'h4) begin miscompares++; $display("FAIL wr_sram_addr: got %h want 4", m_addr); end
        vectors++; if (m_we !== W - 2) begin miscompares++; $display("FAIL wr_we_cycles: got %0d want %0d", m_we, W - 2); end
        vectors++; if (m_doe !== W) begin miscompares++; $display("FAIL wr_data_oe_cycles: got %0d want %0d", m_doe, W); end
        vectors++; if (m_oe !== 0) begin miscompares++; $display("FAIL wr_oe_cycles: got %0d want 0", m_oe); end
        do_access(1'b1, 1'b0, 32'h8000_0010, 4'hF, 32'h0);
        vectors++; if (m_stall !== W + 1) begin miscompares++; $display("FAIL rd_stall: got %0d want %0d", m_stall, W + 1); end
        vectors++; if (m_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rd_data: got %h want deadbeef", m_rdata); end
        vectors++; if (m_oe !== W) begin miscompares++; $display("FAIL rd_oe_cycles: got %0d want %0d", m_oe, W); end
        vectors++; if (m_we !== 0) begin miscompares++; $display("FAIL rd_we_cycles: got %0d want 0", m_we); end
    endtask

    task automatic test_reset_mid_write();
        bus_write = 1'b1; bus_addr = 32'h100; bus_byte_en = 4'hF; bus_write_data = 32'h1357_9BDF;
        repeat (3) @(negedge clk);
        vectors++; if (sram_we_n !== 1'b0) begin miscompares++; $display("FAIL midrst_we_active: got %b want 0", sram_we_n); end
        rst = 1'b1; bus_write = 1'b0;
        @(posedge clk); #1;
        vectors++; if (sram_we_n !== 1'b1) begin miscompares++; $display("FAIL midrst_we_n: got %b want 1", sram_we_n); end
        vectors++; if (sram_ce_n !== 1'b1) begin miscompares++; $display("FAIL midrst_ce_n: got %b want 1", sram_ce_n); end
        vectors++; if (sram_data_oe !== 1'b0) begin miscompares++; $display("FAIL midrst_data_oe: got %b want 0", sram_data_oe); end
        rst = 1'b0; bc_valid = 1'b0;
        @(negedge clk);
        vectors++; if (bus_read_data !== 32'h0) begin miscompares++; $display("FAIL midrst_read_data: got %h want 0", bus_read_data); end
        @(posedge clk); #1;
        do_access(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        vectors++; if (m_stall !== W + 1) begin miscompares++; $display("FAIL midrst_next_stall: got %0d want %0d", m_stall, W + 1); end
    endtask

    task automatic test_byte_lanes();
        do_access(1'b0, 1'b1, 32'h24, 4'hF, 32'h1122_3344);
        do_access(1'b0, 1'b1, 32'h24, 4'b0010, 32'h0000_AA00);
        vectors++; if (m_be !== 4'b1101) begin miscompares++; $display("FAIL lane_be_n: got %b want 1101", m_be); end
        vectors++; if (m_we !== W - 2) begin miscompares++; $display("FAIL lane_we_cycles: got %0d want %0d", m_we, W - 2); end
        vectors++; if (m_we_first !== m_ce_first + 1) begin miscompares++; $display("FAIL lane_we_setup: got we_first %0d want %0d", m_we_first, m_ce_first + 1); end
        vectors++; if (m_we_last !== m_ce_last - 1) begin miscompares++; $display("FAIL lane_we_hold: got we_last %0d want %0d", m_we_last, m_ce_last - 1); end
        do_access(1'b1, 1'b0, 32'h24, 4'h1, 32'h0);
        vectors++; if (m_rdata !== 32'h1122_AA44) begin miscompares++; $display("FAIL lane_read: got %h want 1122aa44", m_rdata); end
        do_access(1'b0, 1'b1, 32'h28, 4'hF, 32'hCAFE_F00D);
        do_access(1'b0, 1'b1, 32'h28, 4'h0, 32'hFFFF_FFFF);
        vectors++; if (m_be !== 4'hF) begin miscompares++; $display("FAIL be0_be_n: got %h want f", m_be); end
        vectors++; if (m_we !== W - 2) begin miscompares++; $display("FAIL be0_we_cycles: got %0d want %0d", m_we, W - 2); end
        do_access(1'b1, 1'b0, 32'h28, 4'hF, 32'h0);
        vectors++; if (m_rdata !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL be0_read: got %h want cafef00d", m_rdata); end
    endtask

    task automatic test_abort();
        int ce;
        ce = 0;
        bus_read = 1'b1; bus_addr = 32'h10; bus_byte_en = 4'hF;
        for (int i = 0; i <= W; i++) begin
            @(negedge clk);
            if (!sram_ce_n) ce++;
            if (i == 2) bus_read = 1'b0;
        end
        @(posedge clk); #1;
        bc_valid = 1'b1; bc_addr = 18'h4;
        vectors++; if (ce !== W) begin miscompares++; $display("FAIL abort_ce_cycles: got %0d want %0d", ce, W); end
        vectors++; if (bus_read_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL abort_read_data: got %h want deadbeef", bus_read_data); end
        do_access(1'b0, 1'b1, 32'h2C, 4'hF, 32'h0BAD_F00D);
        vectors++; if (m_stall !== W + 1) begin miscompares++; $display("FAIL abort_next_stall: got %0d want %0d", m_stall, W + 1); end
        vectors++; if (m_we !== W - 2) begin miscompares++; $display("FAIL abort_next_we: got %0d want %0d", m_we, W - 2); end
        do_access(1'b1, 1'b0, 32'h2C, 4'hF, 32'h0);
    endtask

    task automatic test_rw_both();
        do_access(1'b1, 1'b1, 32'h20, 4'hF, 32'h5A5A_5A5A);
        vectors++; if (m_we !== W - 2) begin miscompares++; $display("FAIL both_we_cycles: got %0d want %0d", m_we, W - 2); end
        vectors++; if (m_oe !== 0) begin miscompares++; $display("FAIL both_oe_cycles: got %0d want 0", m_oe); end
        do_access(1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
        vectors++; if (m_rdata !== 32'h5A5A_5A5A) begin miscompares++; $display("FAIL both_read: got %h want 5a5a5a5a", m_rdata); end
    endtask

    task automatic test_back_to_back();
        int t0, exp_cycles, got_cycles;
        logic wr;
        logic [31:0] a;
        for (int i = 0; i < 4; i++) do_access(1'b0, 1'b1, 32'h40 + 32'(4 * i), 4'hF, $urandom());
        t0 = cyc; exp_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 32'h40 + 32'(4 * $urandom_range(0, 3));
            do_access(!wr, wr, a, 4'($urandom_range(0, 15)), $urandom());
            exp_cycles += m_exp_stall + 1;
            vectors++; if (m_stall !== m_exp_stall) begin miscompares++; $display("FAIL b2b_stall[%0d]: got %0d want %0d", i, m_stall, m_exp_stall); end
        end
        got_cycles = cyc - t0;
        vectors++; if (got_cycles !== exp_cycles) begin miscompares++; $display("FAIL b2b_throughput: got %0d cycles want %0d", got_cycles, exp_cycles); end
    endtask

    task automatic test_cache();
        do_access(1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
        do_access(1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
        vectors++; if (m_stall !== (CACHE_EN ? 1 : W + 1)) begin miscompares++; $display("FAIL cache_repeat_stall: got %0d want %0d", m_stall, CACHE_EN ? 1 : W + 1); end
        vectors++; if (m_ce !== (CACHE_EN ? 0 : W)) begin miscompares++; $display("FAIL cache_repeat_ce: got %0d want %0d", m_ce, CACHE_EN ? 0 : W); end
        do_access(1'b0, 1'b1, 32'h80, 4'hF, 32'h7777_0000);
        do_access(1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
        vectors++; if (m_stall !== W + 1) begin miscompares++; $display("FAIL cache_inval_stall: got %0d want %0d", m_stall, W + 1); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        vectors = 0; miscompares = 0; bc_valid = 1'b0; bc_addr = '0;
        rst = 1'b1; bus_read = 1'b0; bus_write = 1'b0;
        bus_addr = '0; bus_byte_en = '0; bus_write_data = '0;
        test_reset();
        test_write_read();
        test_reset_mid_write();
        test_byte_lanes();
        test_abort();
        test_rw_both();
        test_back_to_back();
        test_cache();
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
